eeprom_page_wr: RTL and testbench
=================================

Name: eeprom_page_wr

Overview:
- I2C master that writes one page (1..PAGE_SIZE bytes) to a 24LC64-class EEPROM.
- Sits upstream of the page-read path. It loads EEPROM contents that the page reader later fetches, and shares the same scl/sda bus and M24LC64 bench model.
- Each byte is pulled from a source through a request/data handshake.
- After STOP, the block waits out the internal write cycle before reporting done.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- SCL_FREQ, 100_000: SCL frequency in Hz. Quarter-bit divider DIV = CLK_FREQ/(4*SCL_FREQ), which must be ≥ 2.
- DEV_ADDR, 3'b000: A2..A1..A0 bits of the control byte.
- PAGE_SIZE, 32: EEPROM page size in bytes, a power of two.
- TWR_CYCLES, 250_000: clk cycles to wait after STOP (5 ms at 50 MHz).

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: synchronous reset, active-high.
- start, input, 1: one-cycle request. Sampled only in IDLE.
- addr, input, 13: first byte address. Latched on an accepted start.
- len, input, 6: byte count, 1..PAGE_SIZE. Latched on an accepted start.
- data_req, output, 1: one-cycle pulse asking for the next byte.
- wr_data, input, 8: the requested byte, sampled on the cycle after data_req.
- busy, output, 1: high from an accepted start until done.
- done, output, 1: one-cycle pulse at the end of every accepted or rejected start.
- ack_err, output, 1: one-cycle pulse, coincident with done, on NACK or rejection.
- scl, output, 1: I2C clock, driven push-pull.
- sda, inout, 1: I2C data, open-drain. Drives 0 or Z; an external pull-up is required.

Behaviour:
- Reset values: busy=0, done=0, ack_err=0, data_req=0, scl=1, sda=Z. State is IDLE and the divider counter is 0.
- Reset mid-operation: on the next clk edge, scl=1 and sda=Z, with no STOP generated. This is acceptable; the EEPROM aborts an uncompleted write.
- Bit timing: a quarter-tick is asserted every DIV clks. Each bit occupies 4 quarters:
  - Q0: scl=0, drive the sda bit.
  - Q1: scl=0.
  - Q2: scl=1; sample sda here.
  - Q3: scl=1.
- Bytes are sent MSB first.
- Start acceptance (start=1 in IDLE):
  - Accept: latch addr and len, set busy next cycle, go to START.
  - Reject when len==0 or addr[4:0]+len > PAGE_SIZE. The block stays IDLE, pulses done and ack_err on the next cycle, and makes no bus activity.
- start is ignored while busy.
- FSM states: IDLE, START, CTRL, ACK_C, ADDR_H, ACK_H, ADDR_L, ACK_L, DATA, ACK_D, STOP, TWR, FIN.
- START: sda goes to 0 while scl=1, then scl goes to 0.
- CTRL: sends {4'b1010, DEV_ADDR, 1'b0}.
- ADDR_H: sends {3'b000, addr[12:8]}.
- ADDR_L: sends addr[7:0].
- ACK states: sda is released during the ACK bit and sampled at Q2.
  - Sampled 1 (NACK): set an err flag and go to STOP.
  - Sampled 0: continue to the next state.
- Data handshake: data_req pulses during Q0 of the last bit of the preceding byte (the ADDR_L or previous DATA byte). wr_data is registered on the following clk and must be valid then; no stall is supported.
- DATA: sends the registered byte. The byte counter decrements after each ACK_D.
  - Counter reaches 0 after ACK: go to STOP.
  - Otherwise: go to DATA for the next byte.
- Exactly len data_req pulses are issued on a fully ACKed transfer.
- STOP: scl=0 with sda=0, then scl=1, then sda goes to Z.
- TWR: entered after STOP only if there was no error. Counts TWR_CYCLES, then goes to FIN. No ACK polling is done.
- FIN: pulse done (and ack_err if the err flag is set), clear busy, return to IDLE.
- After a NACK, the path is STOP then directly FIN, skipping TWR.
- Page-boundary rule: the block never splits a transfer across pages. Oversize requests are rejected at start as described above.

Test Plan:
- Aligned write with M24LC64 (A2..A0=0, WP=0): addr=0x0010, len=4, bytes A1,B2,C3,D4.
  - Exactly 4 data_req pulses; the model accepts START, 0xA0, 0x00, 0x10, then the 4 data bytes, then STOP.
  - done pulses ~TWR_CYCLES after STOP with ack_err=0.
  - A page read at 0x0010 returns A1 B2 C3 D4.
- Full page: addr=0x0040, len=32, bytes 0x00..0x1F. All bytes are ACKed; readback matches; no wrap occurs.
- NACK: set DEV_ADDR=3'b001 with model pins at 0.
  - The CTRL byte is NACKed and STOP follows immediately.
  - done and ack_err pulse together, TWR is skipped, and no data_req is issued.
- Rejection: addr=0x001E, len=4, and separately len=0.
  - done and ack_err pulse one cycle after start; scl stays 1 and sda stays Z throughout.
- Busy guard: a second start pulse mid-transfer is ignored; only one done is produced.
- Reset mid-DATA: assert rst for 1 clk during the second data byte.
  - Next cycle: busy=0, scl=1, sda=Z.
  - A subsequent normal write at 0x0080 succeeds.

Source files
------------

// File: rtl/eeprom_page_wr.sv
// I2C page writer for 24LC64-class EEPROMs: START, control byte, two address bytes, then
// up to one page of data fetched over data_req/wr_data, STOP, and a fixed write-cycle wait.
module eeprom_page_wr #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned SCL_FREQ   = 100_000,
  parameter logic [2:0]  DEV_ADDR   = 3'b000,
  parameter int unsigned PAGE_SIZE  = 32,
  parameter int unsigned TWR_CYCLES = 250_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [12:0] addr,
  input  logic [5:0]  len,
  output logic        data_req,
  input  logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        scl,
  inout  wire         sda
);

  localparam int unsigned DIV = CLK_FREQ / (4 * SCL_FREQ);
  localparam int unsigned DW  = $clog2(DIV);
  localparam int unsigned TW  = $clog2(TWR_CYCLES + 1);

  typedef enum logic [3:0] {
    StIdle, StStart, StCtrl, StAckC, StAddrH, StAckH, StAddrL, StAckL,
    StData, StAckD, StStop, StTwr, StFin
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    q_q, q_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [12:0]   addr_q, addr_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          nack_q, nack_d;
  logic [TW-1:0] twr_q, twr_d;
  logic [7:0]    data_q, data_d;
  logic          scl_q, scl_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ack_err_q, ack_err_d;
  logic          data_req_q, data_req_d;
  logic          tick;
  logic [13:0]   end_sum;

  assign tick    = (div_q == DW'(DIV - 1));
  // Offset within the page plus length; anything past the page end is refused.
  assign end_sum = {1'b0, addr & 13'(PAGE_SIZE - 1)} + {8'd0, len};

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    q_d        = q_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    nack_d     = nack_q;
    twr_d      = twr_q;
    data_d     = data_req_q ? wr_data : data_q;
    scl_d      = scl_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ack_err_d  = 1'b0;
    data_req_d = 1'b0;

    if (state_q inside {StIdle, StTwr, StFin}) div_d = '0;
    else div_d = tick ? '0 : div_q + DW'(1);
    if (tick) q_d = q_q + 2'd1;

    unique case (state_q)
      StIdle: begin
        q_d      = '0;
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        if (start) begin
          if (len == 6'd0 || end_sum > 14'(PAGE_SIZE)) begin
            done_d    = 1'b1;
            ack_err_d = 1'b1;
          end else begin
            addr_d  = addr;
            cnt_d   = len;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = StStart;
          end
        end
      end
      StStart: if (tick) begin
        case (q_q)
          2'd1: sda_oe_d = 1'b1;
          2'd3: begin
            scl_d   = 1'b0;
            shift_d = {4'b1010, DEV_ADDR, 1'b0};
            bit_d   = 3'd7;
            state_d = StCtrl;
          end
          default: ;
        endcase
      end
      StCtrl, StAddrH, StAddrL, StData: if (tick) begin
        case (q_q)
          2'd0: begin
            scl_d    = 1'b0;
            sda_oe_d = ~shift_q[7];
            // Fetch the next byte early so it is registered before the ACK ends.
            if (bit_q == 3'd0 && (state_q == StAddrL || (state_q == StData && cnt_q > 6'd1)))
              data_req_d = 1'b1;
          end
          2'd2: scl_d = 1'b1;
          2'd3: begin
            if (bit_q == 3'd0) begin
              case (state_q)
                StCtrl:  state_d = StAckC;
                StAddrH: state_d = StAckH;
                StAddrL: state_d = StAckL;
                default: state_d = StAckD;
              endcase
            end else begin
              bit_d   = bit_q - 3'd1;
              shift_d = {shift_q[6:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
      StAckC, StAckH, StAckL, StAckD: if (tick) begin
        case (q_q)
          2'd0: begin
            scl_d    = 1'b0;
            sda_oe_d = 1'b0;
          end
          2'd2: begin
            scl_d  = 1'b1;
            nack_d = sda;
          end
          2'd3: begin
            bit_d = 3'd7;
            if (nack_q) begin
              err_d   = 1'b1;
              state_d = StStop;
            end else begin
              case (state_q)
                StAckC: begin
                  shift_d = {3'b000, addr_q[12:8]};
                  state_d = StAddrH;
                end
                StAckH: begin
                  shift_d = addr_q[7:0];
                  state_d = StAddrL;
                end
                StAckD: begin
                  cnt_d   = cnt_q - 6'd1;
                  shift_d = data_q;
                  state_d = (cnt_q == 6'd1) ? StStop : StData;
                end
                default: begin
                  shift_d = data_q;
                  state_d = StData;
                end
              endcase
            end
          end
          default: ;
        endcase
      end
      StStop: if (tick) begin
        case (q_q)
          2'd0: begin
            scl_d    = 1'b0;
            sda_oe_d = 1'b1;
          end
          2'd2: scl_d = 1'b1;
          2'd3: begin
            sda_oe_d = 1'b0;
            twr_d    = '0;
            state_d  = err_q ? StFin : StTwr;
          end
          default: ;
        endcase
      end
      StTwr: begin
        twr_d = twr_q + TW'(1);
        if (twr_q == TW'(TWR_CYCLES - 1)) state_d = StFin;
      end
      StFin: begin
        done_d    = 1'b1;
        ack_err_d = err_q;
        busy_d    = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      div_q      <= '0;
      q_q        <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      nack_q     <= 1'b0;
      twr_q      <= '0;
      data_q     <= '0;
      scl_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      data_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      q_q        <= q_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      nack_q     <= nack_d;
      twr_q      <= twr_d;
      data_q     <= data_d;
      scl_q      <= scl_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      data_req_q <= data_req_d;
    end
  end

  assign scl      = scl_q;
  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ack_err  = ack_err_q;
  assign data_req = data_req_q;

endmodule

// File: tb/tb_eeprom_page_wr.sv
// Bench for eeprom_page_wr: two writers (device pins 000 and 001) share one I2C bus with a
// small 24LC64-style slave model whose pins are tied to 000.
module tb_eeprom_page_wr;

  localparam int unsigned CLK_FREQ  = 1_600_000;
  localparam int unsigned SCL_FREQ  = 100_000;
  localparam int unsigned TWR       = 200;
  localparam logic [8:0]  EV_START  = 9'h100;
  localparam logic [8:0]  EV_STOP   = 9'h101;

  typedef struct {
    bit err;
    int nreq;
    int gmin;
    int gmax;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [12:0] addr = '0;
  logic [5:0]  len = '0;
  logic [7:0]  wr_data = '0;
  logic        data_req0, data_req1, busy0, busy1, done0, done1, err0, err1, scl0, scl1;
  wire         sda;
  wire         scl = scl0 & scl1;
  bit          m_drv = 1'b0;

  pullup pu_sda (sda);
  assign sda = m_drv ? 1'b0 : 1'bz;

  eeprom_page_wr #(.CLK_FREQ(CLK_FREQ), .SCL_FREQ(SCL_FREQ), .DEV_ADDR(3'b000),
                   .PAGE_SIZE(32), .TWR_CYCLES(TWR)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .addr(addr), .len(len), .data_req(data_req0),
    .wr_data(wr_data), .busy(busy0), .done(done0), .ack_err(err0), .scl(scl0), .sda(sda)
  );

  eeprom_page_wr #(.CLK_FREQ(CLK_FREQ), .SCL_FREQ(SCL_FREQ), .DEV_ADDR(3'b001),
                   .PAGE_SIZE(32), .TWR_CYCLES(TWR)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .addr(addr), .len(len), .data_req(data_req1),
    .wr_data(wr_data), .busy(busy1), .done(done1), .ack_err(err1), .scl(scl1), .sda(sda)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_miss = 0;
  int         cyc = 0;
  int         ref_cyc = 0;
  int         req_cnt = 0;
  int         bus_n = 0;
  logic [8:0] exp_bus[$];
  exp_t       exp_done[$];
  logic [7:0] src_q[$];
  logic [7:0] pat[$];
  logic [7:0] mem[0:8191];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_event(input logic [8:0] code);
    check("bus_event_expected", int'(exp_bus.size() > 0), 1);
    if (exp_bus.size() > 0) check($sformatf("bus_ev%0d", bus_n), code, exp_bus.pop_front());
    bus_n++;
  endtask

  // Slave model, oversampling the bus on the falling clk edge.
  bit         p_scl = 1'b1, p_sda = 1'b1, active = 1'b0, in_ack = 1'b0, nacked = 1'b0;
  int         bc = 0, bidx = 0;
  logic [7:0] sr = '0;
  logic [12:0] ptr = '0;

  always @(negedge clk) begin
    if (p_scl && scl && p_sda && !sda) begin
      bus_event(EV_START);
      active = 1'b1; bc = 0; bidx = 0; in_ack = 1'b0; m_drv = 1'b0;
    end else if (p_scl && scl && !p_sda && sda) begin
      bus_event(EV_STOP);
      ref_cyc = cyc; active = 1'b0; m_drv = 1'b0;
    end else if (active && !p_scl && scl && !in_ack) begin
      sr = {sr[6:0], sda};
      bc++;
    end else if (active && p_scl && !scl) begin
      if (in_ack) begin
        in_ack = 1'b0; m_drv = 1'b0; bc = 0;
        if (nacked) active = 1'b0;
      end else if (bc == 8) begin
        bus_event({1'b0, sr});
        in_ack = 1'b1;
        nacked = 1'b0;
        if (bidx == 0) nacked = (sr != 8'hA0);
        else if (bidx == 1) ptr[12:8] = sr[4:0];
        else if (bidx == 2) ptr[7:0] = sr;
        else begin
          mem[ptr] = sr;
          ptr[4:0] = ptr[4:0] + 5'd1;
        end
        m_drv = !nacked;
        bidx++;
      end
    end
    p_scl = scl;
    p_sda = sda;
  end

  // Byte source and done/ack_err scoreboard.
  always @(negedge clk) begin
    if (data_req0 | data_req1) begin
      req_cnt++;
      check("data_req_has_source", int'(src_q.size() > 0), 1);
      if (src_q.size() > 0) wr_data = src_q.pop_front();
    end
    if (err0 | err1)
      check("ack_err_with_done", int'((err0 & done0) | (err1 & done1)), 1);
    if (done0 | done1) begin
      check("done_expected", int'(exp_done.size() > 0), 1);
      if (exp_done.size() > 0) begin
        exp_t e;
        int   gap;
        e   = exp_done.pop_front();
        gap = cyc - ref_cyc;
        check("ack_err", int'(done0 ? err0 : err1), int'(e.err));
        check("data_req_count", req_cnt, e.nreq);
        check($sformatf("done_gap(%0d)", gap), int'(gap >= e.gmin && gap <= e.gmax), 1);
      end
      req_cnt = 0;
    end
  end

  task automatic pulse_start(input bit which, input logic [12:0] a, input logic [5:0] n);
    @(negedge clk);
    addr = a; len = n; ref_cyc = cyc;
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic run_write(input bit which, input logic [2:0] dev, input logic [12:0] a,
                           input bit nack);
    exp_t e;
    exp_bus.push_back(EV_START);
    exp_bus.push_back({1'b0, 4'hA, dev, 1'b0});
    if (!nack) begin
      exp_bus.push_back({4'b0, a[12:8]});
      exp_bus.push_back({1'b0, a[7:0]});
      foreach (pat[i]) begin
        exp_bus.push_back({1'b0, pat[i]});
        src_q.push_back(pat[i]);
      end
    end
    exp_bus.push_back(EV_STOP);
    e.err  = nack;
    e.nreq = nack ? 0 : pat.size();
    e.gmin = nack ? 1 : TWR;
    e.gmax = nack ? 2 : TWR + 4;
    exp_done.push_back(e);
    pulse_start(which, a, 6'(pat.size()));
  endtask

  task automatic wait_idle(input int bound);
    int i = 0;
    while (i < bound && (exp_done.size() != 0 || exp_bus.size() != 0)) begin
      @(negedge clk);
      i++;
    end
    check("drain", exp_done.size() + exp_bus.size(), 0);
    exp_done.delete(); exp_bus.delete(); src_q.delete();
  endtask

  task automatic check_mem(input logic [12:0] a);
    foreach (pat[i]) check($sformatf("mem[%0h]", a + 13'(i)), mem[a + 13'(i)], pat[i]);
  endtask

  task automatic run_reject(input logic [12:0] a, input logic [5:0] n);
    exp_t e;
    int   bad = 0;
    e.err = 1'b1; e.nreq = 0; e.gmin = 1; e.gmax = 1;
    exp_done.push_back(e);
    pulse_start(1'b0, a, n);
    repeat (20) begin
      @(negedge clk);
      if (!scl || !sda || busy0) bad++;
    end
    check("reject_bus_quiet", bad, 0);
    wait_idle(10);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 8'hFF;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_ack_err", err0, 0);
    check("rst_data_req", data_req0, 0);
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);

    pat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_write(1'b0, 3'b000, 13'h0010, 1'b0);
    wait_idle(4000);
    check_mem(13'h0010);

    pat.delete();
    for (int i = 0; i < 32; i++) pat.push_back(8'(i));
    run_write(1'b0, 3'b000, 13'h0040, 1'b0);
    wait_idle(9000);
    check_mem(13'h0040);
    check("no_wrap_below", mem[13'h003F], 8'hFF);
    check("no_wrap_above", mem[13'h0060], 8'hFF);

    pat = '{8'h55, 8'h66};
    run_write(1'b1, 3'b001, 13'h0100, 1'b1);
    wait_idle(2000);
    check("nack_no_write", mem[13'h0100], 8'hFF);

    run_reject(13'h001E, 6'd4);
    run_reject(13'h0000, 6'd0);

    pat = '{8'h5A, 8'hA5};
    run_write(1'b0, 3'b000, 13'h0020, 1'b0);
    repeat (300) @(negedge clk);
    check("busy_mid_transfer", busy0, 1);
    pulse_start(1'b0, 13'h0005, 6'd1);
    wait_idle(3000);
    repeat (50) @(negedge clk);
    check_mem(13'h0020);
    check("ignored_start_no_write", mem[13'h0005], 8'hFF);

    // Interrupt the second data byte with a one-cycle reset while scl is low.
    pat = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (pat[i]) src_q.push_back(pat[i]);
    exp_bus = '{EV_START, 9'h0A0, 9'h000, 9'h060, 9'h011};
    pulse_start(1'b0, 13'h0060, 6'd4);
    for (int i = 0; i < 3000 && exp_bus.size() != 0; i++) @(negedge clk);
    check("pre_reset_bytes", exp_bus.size(), 0);
    repeat (66) @(negedge clk);
    check("req_before_reset", req_cnt, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_scl", scl, 1);
    check("mid_rst_sda", sda, 1);
    @(posedge clk);
    src_q.delete();
    req_cnt = 0;

    pat = '{8'hC0, 8'hC1, 8'hC2};
    run_write(1'b0, 3'b000, 13'h0080, 1'b0);
    wait_idle(4000);
    check_mem(13'h0080);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_miss);
    $fatal(1, "watchdog");
  end

endmodule
